binary_frame_downsampler: RTL and testbench

Reduces the full-resolution binary mask stream from the colour-threshold stage (1280x720) to the 320x180 binary raster consumed by the skeletonizer. Each output pixel is a thresholded population count over a SCALExSCALE input block. The block also gates whole frames against the skeletonizer's `busy`. The skeletonizer has no backpressure, so only complete frames that begin while it is idle are forwarded; all others are dropped in full.

---
 rtl/binary_frame_downsampler_if.sv | 33 +++
 rtl/binary_frame_downsampler.sv | 101 ++++++++++
 tb/tb_binary_frame_downsampler.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/binary_frame_downsampler_if.sv
// Pixel-stream bundle between the colour-threshold stage, the downsampler and
// the skeletonizer: full-resolution mask in, downsampled raster plus frame status out.
interface binary_frame_downsampler_if #(
  parameter int OUT_H = 320,
  parameter int OUT_V = 180
);
  localparam int HW = $clog2(OUT_H);
  localparam int VW = $clog2(OUT_V);

  logic [10:0]   hcount_in;
  logic [9:0]    vcount_in;
  logic          mask_in;
  logic          valid_in;
  logic          skel_busy_in;
  logic          pixel_out;
  logic [HW-1:0] hcount_out;
  logic [VW-1:0] vcount_out;
  logic          valid_out;
  logic          frame_active_out;
  logic          frame_dropped_out;

  modport master (
    output hcount_in, vcount_in, mask_in, valid_in, skel_busy_in,
    input  pixel_out, hcount_out, vcount_out, valid_out,
           frame_active_out, frame_dropped_out
  );

  modport slave (
    input  hcount_in, vcount_in, mask_in, valid_in, skel_busy_in,
    output pixel_out, hcount_out, vcount_out, valid_out,
           frame_active_out, frame_dropped_out
  );
endinterface

// File: rtl/binary_frame_downsampler.sv
// Block-popcount downsampler for the binary mask stream, forwarding only whole
// frames whose SOF arrives while the skeletonizer is idle. SCALE must be >= 2.
module binary_frame_downsampler #(
  parameter int IN_H      = 1280,
  parameter int IN_V      = 720,
  parameter int SCALE     = 4,
  parameter int OUT_H     = IN_H / SCALE,
  parameter int OUT_V     = IN_V / SCALE,
  parameter int THRESHOLD = 8
) (
  input  logic clk_in,
  input  logic rst_n_in,
  binary_frame_downsampler_if.slave bus
);
  localparam int LOG_S  = $clog2(SCALE);
  localparam int PSUM_W = $clog2(SCALE + 1);
  localparam int ACC_W  = $clog2(SCALE * SCALE + 1);
  localparam int COL_W  = $clog2(OUT_H);
  localparam int ROW_W  = $clog2(OUT_V);
  localparam logic [LOG_S-1:0] SUB_LAST = LOG_S'(SCALE - 1);
  localparam logic [ACC_W:0]   THRESH   = (ACC_W + 1)'(THRESHOLD);

  typedef enum logic [1:0] {WAIT_SOF, ACTIVE, DROP} state_t;

  state_t state, state_next;
  logic dropped_next;

  logic accepted, sof, process_px, sub_h_last, emit, frame_last;
  logic [LOG_S-1:0]  sub_h, sub_v;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [PSUM_W-1:0] psum;
  logic [ACC_W-1:0]  hsum;
  logic [ACC_W:0]    block_sum;
  logic [ACC_W-1:0]  acc [OUT_H];

  assign accepted   = bus.valid_in && (bus.hcount_in < 11'(IN_H)) && (bus.vcount_in < 10'(IN_V));
  assign sof        = accepted && (bus.hcount_in == '0) && (bus.vcount_in == '0);
  assign sub_h      = bus.hcount_in[LOG_S-1:0];
  assign sub_v      = bus.vcount_in[LOG_S-1:0];
  assign col        = COL_W'(bus.hcount_in >> LOG_S);
  assign row        = ROW_W'(bus.vcount_in >> LOG_S);
  assign sub_h_last = (sub_h == SUB_LAST);

  // An SOF pixel is consumed in its own cycle whenever it opens a forwarded frame.
  assign process_px = accepted && (sof ? !bus.skel_busy_in : (state == ACTIVE));
  assign emit       = process_px && sub_h_last && (sub_v == SUB_LAST);
  assign frame_last = emit && (col == COL_W'(OUT_H - 1)) && (row == ROW_W'(OUT_V - 1));

  assign hsum      = ACC_W'(psum) + ACC_W'(bus.mask_in);
  assign block_sum = (ACC_W + 1)'(acc[col]) + (ACC_W + 1)'(hsum);

  always_comb begin
    state_next   = state;
    dropped_next = 1'b0;
    if (sof) begin
      if (bus.skel_busy_in) begin
        state_next   = DROP;
        dropped_next = 1'b1;
      end else begin
        state_next = ACTIVE;
      end
    end else if (frame_last) begin
      state_next = WAIT_SOF;
    end
  end

  // frame_active stays up through the cycle carrying the final output pixel.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state                 <= WAIT_SOF;
      psum                  <= '0;
      bus.pixel_out         <= 1'b0;
      bus.hcount_out        <= '0;
      bus.vcount_out        <= '0;
      bus.valid_out         <= 1'b0;
      bus.frame_active_out  <= 1'b0;
      bus.frame_dropped_out <= 1'b0;
    end else begin
      state                 <= state_next;
      bus.frame_active_out  <= (state_next == ACTIVE) || frame_last;
      bus.frame_dropped_out <= dropped_next;
      bus.valid_out         <= emit;
      if (process_px) begin
        psum <= (sub_h == '0) ? PSUM_W'(bus.mask_in) : psum + PSUM_W'(bus.mask_in);
      end
      if (emit) begin
        bus.pixel_out  <= (block_sum >= THRESH);
        bus.hcount_out <= col;
        bus.vcount_out <= row;
      end
    end
  end

  // First block line overwrites, so stale data from aborted frames is never read.
  always_ff @(posedge clk_in) begin
    if (process_px && sub_h_last && (sub_v != SUB_LAST)) begin
      acc[col] <= (sub_v == '0) ? hsum : acc[col] + hsum;
    end
  end
endmodule

// File: tb/tb_binary_frame_downsampler.sv
// Randomised frame-level bench for binary_frame_downsampler on a reduced raster,
// with expectations computed from whole-image block popcounts.
module tb_binary_frame_downsampler;
  localparam int IN_H      = 32;
  localparam int IN_V      = 16;
  localparam int SCALE     = 4;
  localparam int OUT_H     = IN_H / SCALE;
  localparam int OUT_V     = IN_V / SCALE;
  localparam int THRESHOLD = 8;

  typedef struct {
    int col;
    int row;
    int pix;
  } out_pixel_t;

  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b0;

  binary_frame_downsampler_if #(.OUT_H(OUT_H), .OUT_V(OUT_V)) bus ();

  binary_frame_downsampler #(
    .IN_H(IN_H), .IN_V(IN_V), .SCALE(SCALE),
    .OUT_H(OUT_H), .OUT_V(OUT_V), .THRESHOLD(THRESHOLD)
  ) dut (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .bus(bus)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int passes = 0;
  int validCount = 0;
  int dropCount = 0;
  bit expValid = 1'b0;
  bit image [IN_V][IN_H];
  out_pixel_t expQ[$];

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  task automatic applyStimulus(input int h, input int v, input bit m, input bit vld,
                               input bit busy, input bit willEmit);
    bus.hcount_in    = 11'(h);
    bus.vcount_in    = 10'(v);
    bus.mask_in      = m;
    bus.valid_in     = vld;
    bus.skel_busy_in = busy;
    @(posedge clk_in);
    #1;
    expValid = willEmit;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)),
                    1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  function automatic int outputsOr();
    return int'(bus.pixel_out) | int'(bus.hcount_out != '0) | int'(bus.vcount_out != '0) |
           int'(bus.valid_out) | int'(bus.frame_active_out) | int'(bus.frame_dropped_out);
  endfunction

  task automatic fillImage(input int density);
    for (int v = 0; v < IN_V; v++)
      for (int h = 0; h < IN_H; h++)
        image[v][h] = ($urandom_range(0, 99) < density);
  endtask

  task automatic doReset();
    #1;
    rst_n_in = 1'b0;
    #1;
    checkOutput("reset_async_outputs", outputsOr(), 0);
    expValid = 1'b0;
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
  endtask

  // Feeds one frame of image[]; rowsFed < IN_V truncates it, resetRow < rowsFed resets mid-frame.
  task automatic runFrame(input int rowsFed, input bit busyAtSof, input int busyFallRow,
                          input bit blank, input int resetRow);
    bit fwd;
    bit busy;
    bit emitFlag;
    int lastRow;
    int dropsBefore;
    int validsBefore;
    int expPixels;
    int cnt;
    fwd          = !busyAtSof;
    lastRow      = (resetRow < rowsFed) ? resetRow : rowsFed;
    dropsBefore  = dropCount;
    validsBefore = validCount;
    expPixels    = 0;
    if (fwd) begin
      for (int br = 0; br < OUT_V; br++) begin
        if ((br + 1) * SCALE > lastRow) continue;
        for (int bc = 0; bc < OUT_H; bc++) begin
          cnt = 0;
          for (int y = 0; y < SCALE; y++)
            for (int x = 0; x < SCALE; x++)
              cnt += int'(image[br * SCALE + y][bc * SCALE + x]);
          expQ.push_back('{col: bc, row: br, pix: int'(cnt >= THRESHOLD)});
          expPixels++;
        end
      end
    end
    for (int v = 0; v < rowsFed; v++) begin
      if (v == resetRow) begin
        doReset();
        fwd = 1'b0;
      end
      if (v == IN_V / 2) checkOutput("active_mid_frame", int'(bus.frame_active_out), int'(fwd));
      for (int h = 0; h < IN_H; h++) begin
        if ($urandom_range(0, 3) == 0) idleCycles(1);
        if (blank && $urandom_range(0, 2) == 0) begin
          if ($urandom_range(0, 1) == 0) applyStimulus(1300, v, 1'b1, 1'b1, 1'b0, 1'b0);
          else applyStimulus(h, 730, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        if (h == 0 && v == 0) busy = busyAtSof;
        else if (busyAtSof) busy = (v < busyFallRow);
        else busy = 1'($urandom_range(0, 1));
        emitFlag = fwd && (h % SCALE == SCALE - 1) && (v % SCALE == SCALE - 1);
        applyStimulus(h, v, image[v][h], 1'b1, busy, emitFlag);
      end
      idleCycles(2);
    end
    idleCycles(1);
    checkOutput("active_after_frame", int'(bus.frame_active_out), int'(fwd && rowsFed < IN_V));
    checkOutput("valid_count", validCount - validsBefore, expPixels);
    checkOutput("drop_pulses", dropCount - dropsBefore, int'(busyAtSof));
  endtask

  always @(negedge clk_in) begin
    out_pixel_t e;
    if (rst_n_in) begin
      if (bus.valid_out || expValid)
        checkOutput("valid_timing", int'(bus.valid_out), int'(expValid));
      if (bus.valid_out) begin
        validCount++;
        checkOutput("active_at_valid", int'(bus.frame_active_out), 1);
        if (expQ.size() == 0) begin
          checkOutput("unexpected_pixel", 1, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("pixel_col", int'(bus.hcount_out), e.col);
          checkOutput("pixel_row", int'(bus.vcount_out), e.row);
          checkOutput("pixel_value", int'(bus.pixel_out), e.pix);
        end
      end
      if (bus.frame_dropped_out) dropCount++;
    end
  end

  initial begin
    bus.hcount_in    = '0;
    bus.vcount_in    = '0;
    bus.mask_in      = 1'b0;
    bus.valid_in     = 1'b0;
    bus.skel_busy_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    checkOutput("reset_state", outputsOr(), 0);
    rst_n_in = 1'b1;
    idleCycles(3);

    fillImage(100);
    runFrame(IN_V, 1'b0, 0, 1'b0, IN_V);

    fillImage(0);
    for (int i = 0; i < 7; i++) image[i / 4][i % 4] = 1'b1;
    for (int i = 0; i < 8; i++) image[i / 4][4 + i % 4] = 1'b1;
    runFrame(IN_V, 1'b0, 0, 1'b0, IN_V);

    fillImage(50);
    runFrame(IN_V, 1'b1, 6, 1'b0, IN_V);
    fillImage(50);
    runFrame(IN_V, 1'b0, 0, 1'b0, IN_V);

    fillImage(100);
    runFrame(10, 1'b0, 0, 1'b0, IN_V);
    fillImage(0);
    runFrame(IN_V, 1'b0, 0, 1'b0, IN_V);

    fillImage(0);
    runFrame(IN_V, 1'b0, 0, 1'b1, IN_V);

    fillImage(50);
    runFrame(IN_V, 1'b0, 0, 1'b0, 6);
    fillImage(50);
    runFrame(IN_V, 1'b0, 0, 1'b0, IN_V);

    for (int f = 0; f < 4; f++) begin
      fillImage(int'($urandom_range(20, 80)));
      runFrame(IN_V, 1'($urandom_range(0, 1)), int'($urandom_range(1, IN_V - 1)), 1'b1, IN_V);
    end

    idleCycles(5);
    checkOutput("queue_empty", expQ.size(), 0);
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
